ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter and sequencer for the 1024 x 8 `main_memory` port. It sits between the `main_memory` instance in `control_unit` and two masters. Requester 0 is the `eucl` core path (store, load from memory, load memory immediate). Requester 1 is a host/DMA loader that fills RAM while the core runs. It grants one access per cycle, drives the single memory port from the owner, and returns registered read data with a valid strobe.

## Interface
Parameters:
- ADDR_W, 10, RAM address width
- DATA_W, 8, RAM data width
- MAX_BURST, 4, max consecutive locked grants to one requester (range 1..15)

Ports:
- clock  in  1  system clock, all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- req0 / req1  in  1  access request, requester 0 / 1
- lock0 / lock1  in  1  keep ownership for the next access (burst)
- wr0 / wr1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  registered grant; access executes in the cycle gnt is high
- rvalid0 / rvalid1  out  1  read data valid, one cycle after a granted read
- rdata0 / rdata1  out  DATA_W  read data, qualified by rvalid
- mem_en  out  1  to `main_memory` enable
- mem_write  out  1  to `main_memory` Write
- mem_addr  out  ADDR_W  to `main_memory` Address
- mem_din  out  DATA_W  to `main_memory` DataIn
- mem_dout  in  DATA_W  from `main_memory` DataOut (registered read)
- owner  out  2  debug: 00 idle, 01 req0, 10 req1

## Operation
- States:
  - IDLE: no grant.
  - OWN0: gnt0=1.
  - OWN1: gnt1=1.
  - gnt0 and gnt1 are never both high.
- Arbitration runs at every posedge. Inputs are the current req/lock, the state, burst_cnt and the last-winner pointer `last`.
  - In OWNx with reqx & lockx & burst_cnt < MAX_BURST-1: stay in OWNx and increment burst_cnt.
  - Otherwise arbitrate: if neither requests, go to IDLE. If one requests, grant it. If both request, the winner is chosen by the policy in Configuration.
  - On any change of owner, or entry from IDLE, burst_cnt clears to 0 and `last` updates to the new owner.
  - If the burst limit is hit while lockx is still high, ownership is released for arbitration. The same requester may win again if the other is idle.
- Memory port is combinational from the owner:
  - mem_en = gntx & reqx.
  - mem_write = wrx. mem_addr = addrx. mem_din = wdatax.
  - In IDLE, all memory outputs are 0.
- A granted cycle with reqx low is a wasted slot: no access and no rvalid.
- Read return:
  - rvalidx is registered from (gntx & reqx & !wrx) and goes high the next cycle.
  - rdatax = mem_dout, which is valid in that same cycle.
  - rdata holds its last value when rvalid is low.
- Writes produce no response. A write is complete at the end of its gnt cycle.

## Timing
- Request latency, from IDLE: req high in cycle N, gnt in cycle N+1, access at the N+1 → N+2 edge, rvalid/rdata in cycle N+2.
- A requester must hold req, wr, addr and wdata stable until it sees gnt. It drops req (or lock) in the gnt cycle if it needs no further access.
- Locked burst throughput: 1 access/cycle, back-to-back, up to MAX_BURST cycles.
- Unlocked, both requesting: ownership alternates every cycle (RR) or stays with req0 (fixed).
- Reset values: state IDLE, gnt0/1=0, rvalid0/1=0, rdata0/1=0, burst_cnt=0, last=1 (requester 0 wins first), owner=00.
- Reset asserted mid-burst: at the next edge the grant is dropped and the pending rvalid is cancelled. A write executing in the reset cycle still reaches `main_memory`, because `main_memory` has no reset.

## Configuration
- RAM_ARB_RR_EN
  - Defined: round-robin on a tie. The requester that is not `last` wins.
  - Undefined: fixed priority. Requester 0 always wins a tie, and `last` is still tracked for debug only.
- Lock/burst behaviour is identical in both builds.

## Structure
- Shared package `mp_pkg`:
  - Owner encoding constants: OWN_IDLE, OWN_R0, OWN_R1.
  - Arbiter state enum.
  - Defaults RAM_ADDR_W=10 and RAM_DATA_W=8, reused by `main_memory`.
- One natural sub-module: `ram_arb_pick`, the combinational winner select (tie policy plus lock/burst rule), instantiated once.
- The port mux and the rvalid pipeline stay in the top.

## Test plan
- Single read:
  - Preload RAM[0x123]=0xA5.
  - req0 read at 0x123 from IDLE.
  - Expect: gnt0 one cycle later, mem_en=1, mem_addr=0x123, then rvalid0=1 and rdata0=0xA5 the following cycle.
- Write then read:
  - req1 writes 0x3C to 0x3FF, then reads 0x3FF.
  - Expect: rvalid1 with rdata1=0x3C, address wrap boundary correct.
- Tie, RR build:
  - req0 and req1 held high, no lock, 6 cycles.
  - Expect: gnt sequence 0,1,0,1,0,1. In the fixed-priority build, expect gnt0 for all 6 cycles.
- Locked burst, MAX_BURST=4:
  - req0+lock0 held, req1 high.
  - Expect: 4 consecutive gnt0, then gnt1 (RR build), then gnt0 again.
- Wasted slot:
  - req0 dropped in its gnt cycle before an edge with no lock.
  - Expect: mem_en=0, no rvalid0, state returns to IDLE.
- Reset mid-burst:
  - reset_n low during the 2nd locked read.
  - Expect: next cycle gnt=0, rvalid=0, owner=00, and the first post-reset tie goes to requester 0.

Source files
------------

// File: rtl/mp_pkg.sv
// Shared definitions for the main_memory port and its arbiter:
// owner encodings, arbiter state type and default RAM geometry.
package mp_pkg;

    // Default RAM geometry (also used by main_memory)
    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 8;

    // Burst counter width: covers MAX_BURST up to 15
    localparam int BURST_W = 4;

    // Debug owner encoding
    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_R0   = 2'b01;
    localparam logic [1:0] OWN_R1   = 2'b10;

    // Arbiter state; each OWNx state is the registered grant to requester x
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_OWN0 = 2'b01,
        ARB_OWN1 = 2'b10
    } arb_state_t;

    // Map an arbiter state onto the debug owner encoding
    function automatic logic [1:0] owner_of(input arb_state_t s);
        logic [1:0] o;
        case (s)
            ARB_OWN0: o = OWN_R0;
            ARB_OWN1: o = OWN_R1;
            default:  o = OWN_IDLE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for ram_arbiter: lock/burst continuation
// first, then arbitration among the current requests.
// Tie policy selected by macro RAM_ARB_RR_EN:
//   defined   -> round-robin (the requester that did not win last wins)
//   undefined -> fixed priority (requester 0 wins every tie)
module ram_arb_pick
    import mp_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  arb_state_t           i_state,
    input  logic                 i_req0,
    input  logic                 i_req1,
    input  logic                 i_lock0,
    input  logic                 i_lock1,
    input  logic [BURST_W-1:0]   i_burst_cnt,
    input  logic                 i_last,
    output arb_state_t           o_next_state,
    output logic [BURST_W-1:0]   o_next_cnt,
    output logic                 o_next_last
);

    logic [BURST_W-1:0] w_limit;
    logic               w_hold0;
    logic               w_hold1;
    logic               w_tie_win1;

    assign w_limit = BURST_W'(MAX_BURST - 1);

    // A locked owner keeps the port while it is still under the burst limit
    assign w_hold0 = (i_state == ARB_OWN0) && i_req0 && i_lock0 && (i_burst_cnt < w_limit);
    assign w_hold1 = (i_state == ARB_OWN1) && i_req1 && i_lock1 && (i_burst_cnt < w_limit);

`ifdef RAM_ARB_RR_EN
    assign w_tie_win1 = ~i_last;
`else
    assign w_tie_win1 = 1'b0;
`endif

    // Next owner, burst count and last-winner pointer
    always_comb begin
        o_next_state = i_state;
        o_next_cnt   = i_burst_cnt;
        o_next_last  = i_last;
        if (w_hold0 || w_hold1) begin
            o_next_cnt = i_burst_cnt + 1'b1;
        end else begin
            // Every fresh arbitration restarts the burst count, including a
            // re-grant to the same requester after its burst limit.
            o_next_cnt = '0;
            if (!i_req0 && !i_req1) begin
                o_next_state = ARB_IDLE;
            end else if (i_req0 && !i_req1) begin
                o_next_state = ARB_OWN0;
                o_next_last  = 1'b0;
            end else if (!i_req0 && i_req1) begin
                o_next_state = ARB_OWN1;
                o_next_last  = 1'b1;
            end else begin
                o_next_state = w_tie_win1 ? ARB_OWN1 : ARB_OWN0;
                o_next_last  = w_tie_win1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer in front of the single main_memory port.
// Requester 0 is the core path, requester 1 the host/DMA loader. One access
// per cycle executes while gnt is high; reads return one cycle later with a
// valid strobe. Tie policy: macro RAM_ARB_RR_EN (round-robin when defined,
// fixed priority to requester 0 otherwise).
module ram_arbiter
    import mp_pkg::*;
#(
    parameter int ADDR_W    = RAM_ADDR_W,
    parameter int DATA_W    = RAM_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [1:0]        owner
);

    arb_state_t         r_state;
    logic [BURST_W-1:0] r_burst_cnt;
    logic               r_last;
    logic               r_rvalid0;
    logic               r_rvalid1;
    logic [DATA_W-1:0]  r_rdata_hold0;
    logic [DATA_W-1:0]  r_rdata_hold1;

    arb_state_t         w_next_state;
    logic [BURST_W-1:0] w_next_cnt;
    logic               w_next_last;
    logic               w_rd0;
    logic               w_rd1;

    ram_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .i_state      (r_state),
        .i_req0       (req0),
        .i_req1       (req1),
        .i_lock0      (lock0),
        .i_lock1      (lock1),
        .i_burst_cnt  (r_burst_cnt),
        .i_last       (r_last),
        .o_next_state (w_next_state),
        .o_next_cnt   (w_next_cnt),
        .o_next_last  (w_next_last)
    );

    // Grants are the registered state itself
    assign gnt0  = (r_state == ARB_OWN0);
    assign gnt1  = (r_state == ARB_OWN1);
    assign owner = owner_of(r_state);

    // A read executes only when the owner is actually requesting
    assign w_rd0 = gnt0 & req0 & ~wr0;
    assign w_rd1 = gnt1 & req1 & ~wr1;

    // Arbiter state, burst counter and last-winner pointer
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= ARB_IDLE;
            r_burst_cnt <= '0;
            r_last      <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_burst_cnt <= w_next_cnt;
            r_last      <= w_next_last;
        end
    end

    // Memory port driven from the current owner; all zero when idle
    always_comb begin
        mem_en    = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        case (r_state)
            ARB_OWN0: begin
                mem_en    = req0;
                mem_write = wr0;
                mem_addr  = addr0;
                mem_din   = wdata0;
            end
            ARB_OWN1: begin
                mem_en    = req1;
                mem_write = wr1;
                mem_addr  = addr1;
                mem_din   = wdata1;
            end
            default: ;
        endcase
    end

    // Read-valid strobes, one cycle after a granted read; reset cancels them
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_rvalid0 <= w_rd0;
            r_rvalid1 <= w_rd1;
        end
    end

    // Capture returned data so rdata holds between valid strobes
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rdata_hold0 <= '0;
            r_rdata_hold1 <= '0;
        end else begin
            if (r_rvalid0) r_rdata_hold0 <= mem_dout;
            if (r_rvalid1) r_rdata_hold1 <= mem_dout;
        end
    end

    // main_memory output is already registered and valid in the rvalid
    // cycle, so it is passed through directly then and held afterwards.
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rvalid0 ? mem_dout : r_rdata_hold0;
    assign rdata1  = r_rvalid1 ? mem_dout : r_rdata_hold1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural main_memory model.
// Read data is checked by a scoreboard monitor; grants and port muxing are
// checked directly by the stimulus. Expectations follow RAM_ARB_RR_EN.
module tb_ram_arbiter;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req0, req1, lock0, lock1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic [1:0]    owner;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] ram [0:1023];

    logic [5:0] tie_g1;
    logic [5:0] burst_g1;

    always #5 clock = ~clock;

    ram_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .lock0     (lock0),
        .lock1     (lock1),
        .wr0       (wr0),
        .wr1       (wr1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_en    (mem_en),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .owner     (owner)
    );

    // main_memory model: synchronous write, registered read, no reset
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_write) ram[mem_addr] = mem_din;
            else           mem_dout <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: pops an expected value for every read strobe
    always @(negedge clock) begin
        logic [DW-1:0] e;
        if (rvalid0 === 1'b1) begin
            if (q0.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("rdata0", 32'(rdata0), 32'(e));
            end
        end
        if (rvalid1 === 1'b1) begin
            if (q1.size() == 0) check("rvalid1_unexpected", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("rdata1", 32'(rdata1), 32'(e));
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        wr0 = 1'b0; wr1 = 1'b0;
    endtask

    // Finish the current cycle with requests still high, then drop them:
    // the already-decided grant becomes a wasted slot and the port idles.
    task automatic drain(input string tag);
        cyc();
        idle_all();
        @(negedge clock);
        check({tag, "_drain_mem_en"}, 32'(mem_en), 32'd0);
        cyc();
        @(negedge clock);
        check({tag, "_drain_owner"}, 32'(owner), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef RAM_ARB_RR_EN
        tie_g1   = 6'b101010;
        burst_g1 = 6'b010000;
`else
        tie_g1   = 6'b000000;
        burst_g1 = 6'b000000;
`endif
        idle_all();
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        reset_n = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = '0;
        ram[10'h123] = 8'hA5;
        ram[10'h010] = 8'h11;
        ram[10'h020] = 8'h22;

        // Reset state
        repeat (3) cyc();
        @(negedge clock);
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rvalid1", 32'(rvalid1), 32'd0);
        check("rst_rdata0", 32'(rdata0), 32'd0);
        check("rst_rdata1", 32'(rdata1), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        cyc();
        reset_n = 1'b1;

        // Single read from IDLE
        req0 = 1'b1; wr0 = 1'b0; addr0 = 10'h123;
        @(negedge clock);
        check("rd_gnt0_not_yet", 32'(gnt0), 32'd0);
        cyc();
        @(negedge clock);
        check("rd_gnt0", 32'(gnt0), 32'd1);
        check("rd_gnt1", 32'(gnt1), 32'd0);
        check("rd_mem_en", 32'(mem_en), 32'd1);
        check("rd_mem_write", 32'(mem_write), 32'd0);
        check("rd_mem_addr", 32'(mem_addr), 32'h123);
        check("rd_owner", 32'(owner), 32'd1);
        q0.push_back(8'hA5);
        cyc();
        req0 = 1'b0;
        @(negedge clock);
        check("rd_wasted_mem_en", 32'(mem_en), 32'd0);
        cyc();
        @(negedge clock);
        check("rd_idle_gnt0", 32'(gnt0), 32'd0);
        check("rd_idle_owner", 32'(owner), 32'd0);
        check("rd_rdata0_hold", 32'(rdata0), 32'hA5);

        // Requester 1 write then read at the top address
        req1 = 1'b1; wr1 = 1'b1; addr1 = 10'h3FF; wdata1 = 8'h3C;
        cyc();
        @(negedge clock);
        check("wr_gnt1", 32'(gnt1), 32'd1);
        check("wr_gnt0", 32'(gnt0), 32'd0);
        check("wr_mem_en", 32'(mem_en), 32'd1);
        check("wr_mem_write", 32'(mem_write), 32'd1);
        check("wr_mem_addr", 32'(mem_addr), 32'h3FF);
        check("wr_mem_din", 32'(mem_din), 32'h3C);
        check("wr_owner", 32'(owner), 32'd2);
        cyc();
        wr1 = 1'b0;
        @(negedge clock);
        check("wrrd_gnt1", 32'(gnt1), 32'd1);
        check("wrrd_mem_write", 32'(mem_write), 32'd0);
        check("wrrd_mem_addr", 32'(mem_addr), 32'h3FF);
        q1.push_back(8'h3C);
        cyc();
        req1 = 1'b0;
        @(negedge clock);
        check("wrrd_wasted_mem_en", 32'(mem_en), 32'd0);
        cyc();
        @(negedge clock);
        check("wrrd_idle_gnt1", 32'(gnt1), 32'd0);

        // Unlocked tie for 6 cycles
        req0 = 1'b1; req1 = 1'b1; addr0 = 10'h010; addr1 = 10'h020;
        for (int i = 0; i < 6; i++) begin
            cyc();
            @(negedge clock);
            check($sformatf("tie_gnt1_c%0d", i), 32'(gnt1), 32'(tie_g1[i]));
            check($sformatf("tie_gnt0_c%0d", i), 32'(gnt0), 32'(!tie_g1[i]));
            if (gnt0) q0.push_back(8'h11);
            if (gnt1) q1.push_back(8'h22);
        end
        drain("tie");

        // Locked burst by requester 0 with requester 1 competing
        req0 = 1'b1; lock0 = 1'b1; addr0 = 10'h010; addr1 = 10'h020;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 0) req1 = 1'b1;
            @(negedge clock);
            check($sformatf("burst_gnt1_c%0d", i), 32'(gnt1), 32'(burst_g1[i]));
            check($sformatf("burst_gnt0_c%0d", i), 32'(gnt0), 32'(!burst_g1[i]));
            if (gnt0) q0.push_back(8'h11);
            if (gnt1) q1.push_back(8'h22);
        end
        drain("burst");

        // Wasted slot: request withdrawn in the grant cycle
        req0 = 1'b1; lock0 = 1'b0; addr0 = 10'h010;
        cyc();
        req0 = 1'b0;
        @(negedge clock);
        check("waste_gnt0", 32'(gnt0), 32'd1);
        check("waste_mem_en", 32'(mem_en), 32'd0);
        cyc();
        @(negedge clock);
        check("waste_rvalid0", 32'(rvalid0), 32'd0);
        check("waste_gnt0_after", 32'(gnt0), 32'd0);
        check("waste_owner", 32'(owner), 32'd0);

        // Reset during the second locked read
        req0 = 1'b1; lock0 = 1'b1; addr0 = 10'h010;
        cyc();
        @(negedge clock);
        check("rb_gnt0_first", 32'(gnt0), 32'd1);
        q0.push_back(8'h11);
        cyc();
        reset_n = 1'b0;
        @(negedge clock);
        check("rb_gnt0_second", 32'(gnt0), 32'd1);
        cyc();
        idle_all();
        reset_n = 1'b1;
        @(negedge clock);
        check("rb_gnt0", 32'(gnt0), 32'd0);
        check("rb_gnt1", 32'(gnt1), 32'd0);
        check("rb_rvalid0", 32'(rvalid0), 32'd0);
        check("rb_owner", 32'(owner), 32'd0);
        check("rb_rdata0", 32'(rdata0), 32'd0);
        req0 = 1'b1; req1 = 1'b1; addr0 = 10'h010; addr1 = 10'h020;
        cyc();
        @(negedge clock);
        check("rb_tie_gnt0", 32'(gnt0), 32'd1);
        check("rb_tie_gnt1", 32'(gnt1), 32'd0);
        if (gnt0) q0.push_back(8'h11);
        if (gnt1) q1.push_back(8'h22);
        drain("rb");

        cyc();
        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
